// File: rtl/ifu_inst_sram_pkg.sv
// ifu_inst_sram_pkg
// Shared definitions for the instruction-memory responder:
//   - state_e           : responder FSM states (idle / waiting out latency / holding response)
//   - DEFAULT_BASE_ADDR : byte address that maps to word 0 of the array
//   - LFSR_TAPS         : tap mask for x^8+x^6+x^5+x^4+1 (stages 8,6,5,4 -> bits 7,5,4,3)
//   - lfsr_next()       : one Fibonacci step of the jitter LFSR
package ifu_inst_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  localparam logic [7:0]  LFSR_TAPS         = 8'hB8;

  // Shift left, feeding the XOR of the tapped stages into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ifu_inst_sram_array.sv
// ifu_inst_sram_array
// 1R1W word array: synchronous write, asynchronous (combinational) read.
// Contents are never reset; they are filled through the write port.
// Ports:
//   clk      in  clock
//   wr_en    in  write enable, takes effect on the rising edge
//   wr_idx   in  word index to write
//   wr_data  in  word to write
//   rd_idx   in  word index to read
//   rd_data  out word at rd_idx (value before any write on the coming edge)
module ifu_inst_sram_array
  import ifu_inst_sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [31:0]           wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [31:0]           rd_data
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Read is combinational, so a same-edge write is not yet visible here.
  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ifu_inst_sram.sv
// ifu_inst_sram
// Instruction-memory responder on the memory side of the fetch read port.
// Accepts one word read at a time, returns the word after MIN_LAT cycles
// (plus 0..3 LFSR-driven cycles when JITTER_EN), and holds the response
// until the fetch side takes it. A side load port fills the array.
// Ports:
//   clk        in  clock
//   rst        in  asynchronous active-high reset
//   req_valid  in  read request present
//   req_ready  out responder can accept a request (idle only)
//   req_addr   in  byte address of the instruction
//   rsp_valid  out response valid
//   rsp_ready  in  fetch side accepts response
//   rsp_data   out instruction word (0 on error)
//   rsp_err    out request misaligned or outside the array
//   ld_en      in  load-port write enable
//   ld_idx     in  word index for the load
//   ld_data    in  word to load
module ifu_inst_sram
  import ifu_inst_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          MIN_LAT    = 1,
  parameter bit          JITTER_EN  = 1'b0,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [31:0]           ld_data
);

  // MIN_LAT-1 plus up to 3 jitter cycles must fit: 15-1+3 = 17.
  localparam int CNT_W = 5;

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic [7:0]            lfsr;
  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]           rd_word;
  logic                  dec_err;
  logic                  accept;
  logic [CNT_W-1:0]      lat_load;

  // Wrapping subtraction folds addresses below the base into huge offsets,
  // so one range test catches both sides of the window. The base is word
  // aligned, so the offset's low bits are the address's low bits.
  assign offset  = req_addr - BASE_ADDR;
  assign rd_idx  = offset[DEPTH_LOG2+1:2];
  assign dec_err = (offset[1:0] != 2'b00) || (offset[31:DEPTH_LOG2+2] != '0);

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;

  // Counter counts down to zero in WAIT; total latency is load value + 1.
  assign lat_load = CNT_W'(MIN_LAT - 1) + (JITTER_EN ? CNT_W'(lfsr[1:0]) : CNT_W'(0));

  ifu_inst_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_word)
  );

  // The response word is captured at accept, so later loads cannot disturb
  // a pending or held response. The LFSR steps once per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lfsr     <= LFSR_SEED;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_data <= dec_err ? 32'h0 : rd_word;
            rsp_err  <= dec_err;
            cnt      <= lat_load;
            lfsr     <= lfsr_next(lfsr);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
